// File: rtl/injection_arbiter.sv
// Packet-granular round-robin arbiter sharing one serial local-port input among N_SRC serial sources.
// Define INJ_FIXED_PRIO_EN to pin the round-robin pointer at 0 (fixed priority, lowest index wins).

module inj_src_port (
    input  logic pass,
    input  logic hit,
    input  logic out_busy,
    output logic busy
);
    // Only the granted source sees the router's backpressure; everyone else holds.
    assign busy = (pass && hit) ? out_busy : 1'b1;
endmodule

module injection_arbiter #(
    parameter int N_SRC    = 4,
    parameter int PKT_BITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_data,
    output logic [N_SRC-1:0] src_busy,
    output logic             out_data,
    input  logic             out_busy,
    output logic [N_SRC-1:0] grant,
    output logic             active
);
    localparam int SEL_W = $clog2(N_SRC);
    localparam int CNT_W = $clog2(PKT_BITS + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    logic [0:0]       state;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] ptr_next;
    logic [CNT_W-1:0] cnt;
    logic             req_any;
    logic             pass;
    logic             last_bit;

    // Scan from the farthest offset down so the offset closest to ptr wins.
    always_comb begin
        win     = '0;
        req_any = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (src_data[(int'(ptr) + k) % N_SRC]) begin
                win     = SEL_W'((int'(ptr) + k) % N_SRC);
                req_any = 1'b1;
            end
        end
    end

    assign pass     = (state == ST_PASS);
    assign last_bit = (cnt == CNT_W'(PKT_BITS));
    assign ptr_next = (sel == SEL_W'(N_SRC - 1)) ? '0 : sel + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        sel   <= win;
                        cnt   <= '0;
                        state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    // A busy cycle freezes everything; the source is holding its bit.
                    if (!out_busy) begin
                        if (last_bit) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
`ifdef INJ_FIXED_PRIO_EN
                            ptr   <= '0;
`else
                            ptr   <= ptr_next;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign active   = pass;
    assign grant    = pass ? (N_SRC'(1) << sel) : '0;
    assign out_data = pass & src_data[sel];

    for (genvar i = 0; i < N_SRC; i++) begin : g_port
        inj_src_port u_port (
            .pass     (pass),
            .hit      (sel == SEL_W'(i)),
            .out_busy (out_busy),
            .busy     (src_busy[i])
        );
    end

endmodule

// File: tb/tb_injection_arbiter.sv
// Directed + randomized bench for injection_arbiter: packet-level reference model with
// serial source emulation and a per-packet scoreboard.

module tb_injection_arbiter;
    localparam int N = 4;
    localparam int P = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] src_data;
    logic [N-1:0] src_busy;
    logic         out_data;
    logic         out_busy;
    logic [N-1:0] grant;
    logic         active;

    injection_arbiter #(.N_SRC(N), .PKT_BITS(P)) dut (
        .clk      (clk),
        .reset    (reset),
        .src_data (src_data),
        .src_busy (src_busy),
        .out_data (out_data),
        .out_busy (out_busy),
        .grant    (grant),
        .active   (active)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // source emulation: pending bits per source, and payloads expected at the output
    bit           qs[N][$];
    logic [P-1:0] exp_pkts[N][$];
    logic [N-1:0] winners[$];

    // reference model: who owns the output, bits accepted so far, next search start
    int m_owner = -1;
    int m_acc   = 0;
    int m_ptr   = 0;
    bit new_pass = 0;
    logic [P:0] rx_word = '0;

    int bp_mode  = 0;
    int bp_pct   = 0;
    int bp_left  = 0;
    bit rst_trig = 0;
    bit hold_rst = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int i, input logic [P-1:0] w);
        qs[i].push_back(1'b1);
        for (int b = P - 1; b >= 0; b--) qs[i].push_back(w[b]);
        exp_pkts[i].push_back(w);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) src_data[i] = (qs[i].size() > 0) ? qs[i][0] : 1'b0;
        out_busy = 1'b0;
        if (bp_mode == 1) out_busy = ($urandom_range(99) < 32'(bp_pct));
        if (bp_mode == 2 && m_owner >= 0 && m_acc == 7 && bp_left > 0) begin
            out_busy = 1'b1;
            bp_left--;
        end
    endtask

    task automatic step();
        logic [N-1:0] e_busy, e_grant, pop;
        logic         e_data, e_act;
        int           j;
        @(negedge clk);
        if (m_owner < 0) begin
            e_grant = '0; e_act = 1'b0; e_data = 1'b0; e_busy = '1;
        end else begin
            e_grant = N'(1) << m_owner;
            e_act   = 1'b1;
            e_data  = src_data[m_owner];
            e_busy  = '1;
            e_busy[m_owner] = out_busy;
        end
        check("grant",    32'(grant),    32'(e_grant));
        check("active",   32'(active),   32'(e_act));
        check("out_data", 32'(out_data), 32'(e_data));
        check("src_busy", 32'(src_busy), 32'(e_busy));
        if (new_pass) begin
            winners.push_back(grant);
            new_pass = 0;
        end
        pop = '0;
        for (int i = 0; i < N; i++) if (qs[i].size() > 0 && !src_busy[i]) pop[i] = 1'b1;
        if (m_owner >= 0 && !out_busy) rx_word = {rx_word[P-1:0], out_data};
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                qs[i].delete();
                exp_pkts[i].delete();
            end
            m_owner = -1; m_acc = 0; m_ptr = 0; new_pass = 0;
        end else begin
            for (int i = 0; i < N; i++) if (pop[i]) void'(qs[i].pop_front());
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (m_owner < 0 && src_data[j]) begin
                        m_owner = j; m_acc = 0; new_pass = 1;
                    end
                end
            end else if (!out_busy) begin
                m_acc++;
                if (m_acc == P + 1) begin
                    if (exp_pkts[m_owner].size() == 0) check("pkt_unexpected", 32'(m_owner), 32'hffff);
                    else check("packet", 32'(rx_word), 32'({1'b1, exp_pkts[m_owner].pop_front()}));
`ifdef INJ_FIXED_PRIO_EN
                    m_ptr = 0;
`else
                    m_ptr = (m_owner + 1) % N;
`endif
                    m_owner = -1; m_acc = 0;
                end
            end
        end
        #1;
        if (rst_trig && m_owner == 1 && m_acc == 9) begin
            reset = 1'b1;
            rst_trig = 0;
        end else if (!hold_rst) begin
            reset = 1'b0;
        end
        drive();
    endtask

    function automatic bit pending();
        pending = (m_owner >= 0);
        for (int i = 0; i < N; i++) if (qs[i].size() > 0) pending = 1;
    endfunction

    task automatic run_idle(input string tag, output int cycles);
        cycles = 0;
        drive();
        do begin
            step();
            cycles++;
        end while (pending() && cycles < 3000);
        check({tag, "_timeout"}, 32'(cycles < 3000), 32'd1);
    endtask

    task automatic do_reset();
        hold_rst = 1; reset = 1'b1;
        step();
        hold_rst = 0; reset = 1'b0;
        winners.delete();
    endtask

    initial begin
        int c;
        logic [N-1:0] ord[8];
        reset = 1'b1; src_data = '0; out_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // idle after reset, then a lone packet from source 2
        send(2, 16'hA5C3);
        run_idle("single", c);
        check("single_cycles", 32'(c), 32'd18);
        check("single_grant", 32'(winners[0]), 32'b0100);
        winners.delete();
        send(1, 16'h1234);
        send(3, 16'h4321);
        run_idle("after_single", c);
`ifdef INJ_FIXED_PRIO_EN
        check("ptr3_first", 32'(winners[0]), 32'b0010);
`else
        check("ptr3_first", 32'(winners[0]), 32'b1000);
`endif

        // simultaneous 0 and 3 from reset
        do_reset();
        send(0, 16'hBEEF);
        send(3, 16'h0F0F);
        run_idle("two", c);
        check("two_cycles", 32'(c), 32'd36);
        check("two_first",  32'(winners[0]), 32'b0001);
        check("two_second", 32'(winners[1]), 32'b1000);

        // backpressure holding the packet at 7 accepted bits
        do_reset();
        bp_mode = 2; bp_left = 5;
        send(1, 16'hC0DE);
        run_idle("bp", c);
        check("bp_cycles", 32'(c), 32'd23);
        bp_mode = 0;

        // all four continuously requesting
        do_reset();
        for (int i = 0; i < N; i++) begin
            send(i, 16'($urandom));
            send(i, 16'($urandom));
        end
        run_idle("all4", c);
        check("all4_cycles", 32'(c), 32'd144);
        for (int k = 0; k < 8; k++) begin
`ifdef INJ_FIXED_PRIO_EN
            ord[k] = N'(1) << (k / 2);
`else
            ord[k] = N'(1) << (k % 4);
`endif
            check("all4_order", 32'(winners[k]), 32'(ord[k]));
        end

        // reset mid-packet, then pointer must be back at 0
        do_reset();
        rst_trig = 1;
        send(1, 16'hFFFF);
        run_idle("rst_mid", c);
        winners.delete();
        send(2, 16'h5555);
        send(0, 16'hAAAA);
        run_idle("post_rst", c);
        check("post_rst_first", 32'(winners[0]), 32'b0001);

        // sources 1 and 2 both requesting
        do_reset();
        send(1, 16'h0001); send(1, 16'h0002); send(1, 16'h0003);
        send(2, 16'h0004);
        run_idle("prio", c);
`ifdef INJ_FIXED_PRIO_EN
        check("prio_0", 32'(winners[0]), 32'b0010);
        check("prio_1", 32'(winners[1]), 32'b0010);
        check("prio_2", 32'(winners[2]), 32'b0010);
        check("prio_3", 32'(winners[3]), 32'b0100);
`else
        check("prio_0", 32'(winners[0]), 32'b0010);
        check("prio_1", 32'(winners[1]), 32'b0100);
        check("prio_2", 32'(winners[2]), 32'b0010);
        check("prio_3", 32'(winners[3]), 32'b0010);
`endif

        // random traffic with random backpressure
        do_reset();
        bp_mode = 1; bp_pct = 25;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(99) < 8) begin
                int s;
                s = int'($urandom_range(N - 1));
                if (exp_pkts[s].size() < 2) send(s, 16'($urandom));
            end
            step();
        end
        run_idle("rand", c);
        for (int i = 0; i < N; i++) check("rand_drained", 32'(exp_pkts[i].size()), 32'd0);
        bp_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
